// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl -- SPI mode 0 master transfer sequencer.
//
// Runs one DATA_W-bit full-duplex transfer per accepted start. The SCK itself
// comes from an external clock divider: this block enables that divider and
// hands it a bitrate, then watches the returned SCK (sck_in) for edges. MISO
// is sampled on SCK rise and MOSI is advanced on SCK fall.
//
// Build option:
//   SPI_XFER_CTRL_LSB_FIRST_EN  defined   -> LSB-first transmit and receive
//                               undefined -> MSB-first (default)
//
// Ports:
//   clk_cpu      in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle transfer request (honoured only when idle)
//   tx_data      in   word to send, captured on an accepted start
//   bitrate_in   in   divider count, captured on an accepted start (0 -> 1)
//   sck_in       in   SCK returned by the external divider
//   miso         in   serial data from the slave
//   div_en       out  divider enable, high only while bits are moving
//   div_bitrate  out  bitrate held for the divider
//   cs_n         out  active-low slave select
//   mosi         out  serial data to the slave, 0 while deselected
//   busy         out  transfer in progress
//   done         out  one-cycle pulse, rx_data valid
//   rx_data      out  last received word, held until the next done
module spi_xfer_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [31:0]       bitrate_in,
  input  logic              sck_in,
  input  logic              miso,
  output logic              div_en,
  output logic [31:0]       div_bitrate,
  output logic              cs_n,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [5:0] BIT_LAST = 6'(DATA_W);

  logic [1:0]        state_q,       state_d;
  logic [DATA_W-1:0] tx_sh_q,       tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q,       rx_sh_d;
  logic [5:0]        bit_cnt_q,     bit_cnt_d;
  logic              sck_d_q;
  logic              cs_n_q,        cs_n_d;
  logic              div_en_q,      div_en_d;
  logic              mosi_q,        mosi_d;
  logic              busy_q,        busy_d;
  logic              done_q,        done_d;
  logic [DATA_W-1:0] rx_data_q,     rx_data_d;
  logic [31:0]       div_bitrate_q, div_bitrate_d;

  logic sck_rise;
  logic sck_fall;

  // Bit-order helpers: the transmit head is always the bit currently on the
  // wire, so advancing the shifter and re-reading the head gives the next bit.
  function automatic logic tx_head(input logic [DATA_W-1:0] w);
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w,
                                                 input logic              b);
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  assign sck_rise =  sck_in & ~sck_d_q;
  assign sck_fall = ~sck_in &  sck_d_q;

  always_comb begin
    state_d       = state_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    cs_n_d        = cs_n_q;
    div_en_d      = div_en_q;
    mosi_d        = mosi_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rx_data_d     = rx_data_q;
    div_bitrate_d = div_bitrate_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sh_d       = tx_data;
          // A zero count would make the divider wrap; clamp to the fastest legal rate.
          div_bitrate_d = (bitrate_in == 32'd0) ? 32'd1 : bitrate_in;
          bit_cnt_d     = '0;
          busy_d        = 1'b1;
          cs_n_d        = 1'b0;
          mosi_d        = tx_head(tx_data);
          state_d       = ST_SETUP;
        end
      end

      ST_SETUP: begin
        // First bit has been on mosi with cs_n low for one cycle; start SCK.
        div_en_d = 1'b1;
        state_d  = ST_XFER;
      end

      ST_XFER: begin
        if (sck_rise) begin
          rx_sh_d   = rx_insert(rx_sh_q, miso);
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (sck_fall) begin
          if (bit_cnt_q == BIT_LAST) begin
            div_en_d = 1'b0;
            state_d  = ST_HOLD;
          end else begin
            tx_sh_d = tx_advance(tx_sh_q);
            mosi_d  = tx_head(tx_advance(tx_sh_q));
          end
        end
      end

      ST_HOLD: begin
        div_en_d  = 1'b0;
        cs_n_d    = 1'b1;
        mosi_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        rx_data_d = rx_sh_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        cs_n_d   = 1'b1;
        div_en_d = 1'b0;
        mosi_d   = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      sck_d_q       <= 1'b0;
      cs_n_q        <= 1'b1;
      div_en_q      <= 1'b0;
      mosi_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rx_data_q     <= '0;
      div_bitrate_q <= 32'd1;
    end else begin
      state_q       <= state_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      sck_d_q       <= sck_in;
      cs_n_q        <= cs_n_d;
      div_en_q      <= div_en_d;
      mosi_q        <= mosi_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rx_data_q     <= rx_data_d;
      div_bitrate_q <= div_bitrate_d;
    end
  end

  assign div_en      = div_en_q;
  assign div_bitrate = div_bitrate_q;
  assign cs_n        = cs_n_q;
  assign mosi        = mosi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural clock divider
// (SCK half period = div_bitrate + 1 clk_cpu cycles) and a slave that is
// either a MOSI->MISO loopback or a fixed-word responder.
// Honours SPI_XFER_CTRL_LSB_FIRST_EN for expected bit order.
module tb_spi_xfer_ctrl;

  logic        clk_cpu = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  tx_data;
  logic [31:0] bitrate_in;
  logic        sck;
  logic        miso;
  logic        div_en;
  logic [31:0] div_bitrate;
  logic        cs_n;
  logic        mosi;
  logic        busy;
  logic        done;
  logic [7:0]  rx_data;

  int vectors    = 0;
  int miscompares = 0;

  spi_xfer_ctrl #(.DATA_W(8)) dut (
    .clk_cpu     (clk_cpu),
    .rst         (rst),
    .start       (start),
    .tx_data     (tx_data),
    .bitrate_in  (bitrate_in),
    .sck_in      (sck),
    .miso        (miso),
    .div_en      (div_en),
    .div_bitrate (div_bitrate),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .busy        (busy),
    .done        (done),
    .rx_data     (rx_data)
  );

  always #5 clk_cpu = ~clk_cpu;

  // External clock divider.
  logic [31:0] dcnt;
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      sck  <= 1'b0;
      dcnt <= '0;
    end else if (!div_en) begin
      sck  <= 1'b0;
      dcnt <= '0;
    end else if (dcnt >= div_bitrate) begin
      dcnt <= '0;
      sck  <= ~sck;
    end else begin
      dcnt <= dcnt + 32'd1;
    end
  end

  function automatic logic exp_bit(input logic [7:0] w, input int k);
`ifdef SPI_XFER_CTRL_LSB_FIRST_EN
    return w[k];
`else
    return w[7-k];
`endif
  endfunction

  // Passive monitor, sampled on the falling clk_cpu edge.
  int   cyc = 0;
  int   rises_total = 0;
  int   falls_total = 0;
  int   dones_total = 0;
  int   cs_viol = 0;
  int   idle_mosi_viol = 0;
  logic sck_prev = 1'b0;
  logic mosi_log [0:1023];
  int   rise_cyc [0:1023];

  always @(negedge clk_cpu) begin
    cyc++;
    if (sck && !sck_prev) begin
      if (rises_total < 1024) begin
        mosi_log[rises_total] = mosi;
        rise_cyc[rises_total] = cyc;
      end
      rises_total++;
      if (cs_n) cs_viol++;
    end
    if (!sck && sck_prev) falls_total++;
    if (done) dones_total++;
    if (cs_n && mosi) idle_mosi_viol++;
    sck_prev = sck;
  end

  // Slave: loopback, or a fixed word presented one bit per SCK fall.
  logic       loop_en;
  logic [7:0] slave_word;
  int         fall_base;
  logic       slave_bit;
  int         sk;
  always_comb begin
    sk        = falls_total - fall_base;
    slave_bit = 1'b0;
    if (sk >= 0 && sk < 8) slave_bit = exp_bit(slave_word, sk);
  end
  assign miso = loop_en ? mosi : slave_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_cpu);
  endtask

  // Drives start for one cycle, then scrambles the sampled inputs.
  task automatic start_xfer(input logic [7:0] tx, input logic [31:0] br);
    start      = 1'b1;
    tx_data    = tx;
    bitrate_in = br;
    step(1);
    start      = 1'b0;
    tx_data    = ~tx;
    bitrate_in = 32'd7;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    check({tag, " done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [31:0] br,
                          input logic [31:0] exp_div, input logic [7:0] exp_rx);
    int r0, d0;
    r0 = rises_total;
    d0 = dones_total;
    start_xfer(tx, br);
    check({tag, " setup_busy"},   32'(busy),   32'd1);
    check({tag, " setup_cs_n"},   32'(cs_n),   32'd0);
    check({tag, " setup_div_en"}, 32'(div_en), 32'd0);
    check({tag, " setup_mosi"},   32'(mosi),   32'(exp_bit(tx, 0)));
    check({tag, " div_bitrate"},  div_bitrate, exp_div);
    step(1);
    check({tag, " xfer_div_en"},  32'(div_en), 32'd1);
    wait_done(tag);
    check({tag, " rx_data"},      32'(rx_data), 32'(exp_rx));
    check({tag, " done_busy"},    32'(busy),    32'd0);
    check({tag, " done_cs_n"},    32'(cs_n),    32'd1);
    step(1);
    check({tag, " done_pulse_end"}, 32'(done),  32'd0);
    check({tag, " rx_held"},      32'(rx_data), 32'(exp_rx));
    step(2);
    check({tag, " sck_rises"},    32'(rises_total - r0), 32'd8);
    check({tag, " done_count"},   32'(dones_total - d0), 32'd1);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s mosi_bit%0d", tag, k), 32'(mosi_log[r0+k]), 32'(exp_bit(tx, k)));
    check({tag, " sck_period"}, 32'(rise_cyc[r0+1] - rise_cyc[r0]), 2 * (exp_div + 32'd1));
  endtask

  initial begin
    int r0, d0, n;
    rst        = 1'b1;
    start      = 1'b0;
    tx_data    = 8'h00;
    bitrate_in = 32'd0;
    loop_en    = 1'b1;
    slave_word = 8'h00;
    fall_base  = 0;
    step(2);

    // Reset state
    check("rst cs_n",        32'(cs_n),    32'd1);
    check("rst div_en",      32'(div_en),  32'd0);
    check("rst mosi",        32'(mosi),    32'd0);
    check("rst busy",        32'(busy),    32'd0);
    check("rst done",        32'(done),    32'd0);
    check("rst rx_data",     32'(rx_data), 32'd0);
    check("rst div_bitrate", div_bitrate,  32'd1);
    rst = 1'b0;
    step(2);

    // Loopback 0xA5 at bitrate 2
    run_xfer("loop_a5", 8'hA5, 32'd2, 32'd2, 8'hA5);

    // Fixed slave word 0x3C, bitrate 0 clamps to 1
    loop_en    = 1'b0;
    slave_word = 8'h3C;
    fall_base  = falls_total;
    run_xfer("slave_3c", 8'hFF, 32'd0, 32'd1, 8'h3C);
    loop_en    = 1'b1;
    step(2);

    // Start while busy is ignored
    r0 = rises_total;
    d0 = dones_total;
    start_xfer(8'hA5, 32'd2);
    step(5);
    start      = 1'b1;
    tx_data    = 8'h00;
    bitrate_in = 32'd9;
    step(1);
    start      = 1'b0;
    check("busy_start div_bitrate", div_bitrate, 32'd2);
    wait_done("busy_start");
    check("busy_start rx_data", 32'(rx_data), 32'hA5);
    step(6);
    check("busy_start done_count", 32'(dones_total - d0), 32'd1);
    check("busy_start sck_rises",  32'(rises_total - r0), 32'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("busy_start mosi_bit%0d", k), 32'(mosi_log[r0+k]), 32'(exp_bit(8'hA5, k)));
    check("busy_start idle", 32'(busy), 32'd0);

    // Reset after the 4th SCK rise aborts the transfer
    r0 = rises_total;
    d0 = dones_total;
    start_xfer(8'h5A, 32'd2);
    n = 0;
    while ((rises_total - r0) < 4 && n < 200) begin
      step(1);
      n++;
    end
    check("abort reached_rise4", 32'(rises_total - r0), 32'd4);
    rst = 1'b1;
    #1;
    check("abort cs_n",   32'(cs_n),   32'd1);
    check("abort div_en", 32'(div_en), 32'd0);
    check("abort busy",   32'(busy),   32'd0);
    check("abort mosi",   32'(mosi),   32'd0);
    step(2);
    rst = 1'b0;
    step(30);
    check("abort no_done", 32'(dones_total - d0), 32'd0);
    check("abort rx_data", 32'(rx_data), 32'd0);
    run_xfer("after_abort_5a", 8'h5A, 32'd2, 32'd2, 8'h5A);

    // Single set bit exposes bit order
    run_xfer("order_01", 8'h01, 32'd2, 32'd2, 8'h01);

    // Back-to-back: second start on the cycle after done
    d0 = dones_total;
    start_xfer(8'hA5, 32'd2);
    wait_done("b2b_first");
    check("b2b_first rx_data", 32'(rx_data), 32'hA5);
    check("b2b gap_cs_n0", 32'(cs_n), 32'd1);
    step(1);
    check("b2b gap_cs_n1", 32'(cs_n), 32'd1);
    start_xfer(8'h3C, 32'd1);
    check("b2b second_busy", 32'(busy), 32'd1);
    check("b2b second_cs_n", 32'(cs_n), 32'd0);
    wait_done("b2b_second");
    check("b2b_second rx_data", 32'(rx_data), 32'h3C);
    step(3);
    check("b2b done_count", 32'(dones_total - d0), 32'd2);

    check("cs_n_low_at_rises", 32'(cs_viol),        32'd0);
    check("mosi_zero_idle",    32'(idle_mosi_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer (legal range 2..32).
REQ-002 SHALL have port clk_cpu  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-005 SHALL have port tx_data  input  DATA_W  word to transmit; sampled on accepted start.
REQ-006 SHALL have port bitrate_in  input  32  requested divider count; sampled on accepted start.
REQ-007 SHALL have port sck_in  input  1  SCK returned from the external clock divider.
REQ-008 SHALL have port miso  input  1  serial data from the slave.
REQ-009 SHALL have port div_en  output  1  enable to the clock divider.
REQ-010 SHALL have port div_bitrate  output  32  latched bitrate to the clock divider.
REQ-011 SHALL have port cs_n  output  1  active-low slave select.
REQ-012 SHALL have port mosi  output  1  serial data to the slave.
REQ-013 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse when rx_data is valid.
REQ-015 SHALL have port rx_data  output  DATA_W  last received word; held until the next done.

Function
REQ-016 SHALL use SPI mode 0: SCK idles low, MISO sampled on SCK rise, MOSI changed on SCK fall.
REQ-017 SHALL detect SCK edges from a one-flop delayed copy of sck_in: rise = sck_in & ~sck_d; fall = ~sck_in & sck_d.
REQ-018 SHALL implement the states IDLE, SETUP, XFER and HOLD.
REQ-019 IDLE: cs_n=1, div_en=0, busy=0; on start=1, SHALL latch tx_data into the shift register, latch bitrate_in into div_bitrate, and go to SETUP.
REQ-020 SHALL load div_bitrate with 1 when bitrate_in is 0, which prevents divider count wrap-around.
REQ-021 SETUP (exactly 1 cycle): cs_n=0, mosi=first bit, div_en=0; then go to XFER.
REQ-022 XFER: div_en=1; on each rise, SHALL shift miso into the receive register and increment the 6-bit bit counter.
REQ-023 XFER: on each fall, if the bit counter equals DATA_W, SHALL drop div_en and go to HOLD; otherwise SHALL present the next bit on mosi.
REQ-024 HOLD (exactly 1 cycle): cs_n=0, div_en=0; then SHALL return to IDLE, raising cs_n and copying the receive register to rx_data with done=1 in that same cycle.
REQ-025 SHALL ignore start while busy=1 or while in HOLD; no queuing is performed.
REQ-026 SHALL hold mosi at 0 whenever cs_n=1.
REQ-027 SHALL not sample tx_data or bitrate_in except on an accepted start.

Reset
REQ-028 SHALL, on rst=1, immediately force: state=IDLE, cs_n=1, div_en=0, mosi=0, busy=0, done=0, rx_data=0, div_bitrate=1, bit counter=0, sck_d=0.
REQ-029 SHALL abort any in-progress transfer on reset mid-transfer, without a done pulse and without updating rx_data.

Configuration
REQ-030 SHALL use macro SPI_XFER_CTRL_LSB_FIRST_EN: when it is defined, transmit and receive bit order is LSB first; when it is undefined, bit order is MSB first.

Verification
REQ-031 Bench SHALL use the real divider with loopback miso=mosi: DATA_W=8, bitrate_in=2, tx_data=0xA5 -> mosi sequence 1,0,1,0,0,1,0,1, rx_data=0xA5, single done pulse, exactly 8 SCK rises, cs_n low throughout.
REQ-032 Bench SHALL drive a slave model returning 0x3C with tx_data=0xFF and bitrate_in=0 -> div_bitrate=1, rx_data=0x3C, SCK period 4 clk_cpu cycles.
REQ-033 Bench SHALL pulse start again while busy with tx_data=0x00 -> transfer of 0xA5 unaffected and exactly one done pulse.
REQ-034 Bench SHALL assert rst after the 4th SCK rise -> cs_n=1 and div_en=0 same cycle, no done pulse, rx_data stays 0; a following 0x5A transfer completes correctly.
REQ-035 Bench SHALL build with SPI_XFER_CTRL_LSB_FIRST_EN and tx_data=0x01 -> first mosi bit 1 then seven 0s; loopback rx_data=0x01.
REQ-036 Bench SHALL issue back-to-back starts on the cycle after done -> both accepted, cs_n high for at least 1 cycle between transfers.
